// File: rtl/cel_pack_pkg.sv
// Shared constants, state encoding and helpers for the packed CEL row decoder.
package cel_pack_pkg;

  localparam logic [1:0] PACK_EOL     = 2'b00;
  localparam logic [1:0] PACK_LITERAL = 2'b01;
  localparam logic [1:0] PACK_TRANSP  = 2'b10;
  localparam logic [1:0] PACK_REPEAT  = 2'b11;

  localparam logic [2:0] BPP_1  = 3'd1;
  localparam logic [2:0] BPP_2  = 3'd2;
  localparam logic [2:0] BPP_4  = 3'd3;
  localparam logic [2:0] BPP_6  = 3'd4;
  localparam logic [2:0] BPP_8  = 3'd5;
  localparam logic [2:0] BPP_16 = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_PKT,
    ST_LIT,
    ST_TRN,
    ST_REP_LD,
    ST_REP,
    ST_DRAIN
  } state_t;

  // Pixel width in bits for a bpp code; 0 marks an unsupported code.
  function automatic logic [4:0] bpp_bits(input logic [2:0] code);
    case (code)
      BPP_1:   return 5'd1;
      BPP_2:   return 5'd2;
      BPP_4:   return 5'd4;
      BPP_6:   return 5'd6;
      BPP_8:   return 5'd8;
      BPP_16:  return 5'd16;
      default: return 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/cel_bit_accum.sv
// MSB-aligned bit accumulator: words append below the valid bits, consumed
// bits leave from the top. Push and pop may happen in the same cycle.
module cel_bit_accum #(
  parameter int WORD_W = 32,
  parameter int ACC_W  = 64,
  parameter int LVL_W  = $clog2(ACC_W + 1)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              push,
  input  logic [WORD_W-1:0] word,
  input  logic [4:0]        pop_n,
  output logic [15:0]       head,
  output logic [LVL_W-1:0]  level
);

  localparam logic [LVL_W-1:0] LVL_ROOM = LVL_W'(ACC_W - WORD_W);
  localparam logic [LVL_W-1:0] LVL_WORD = LVL_W'(WORD_W);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_pop;
  logic [ACC_W-1:0] word_ext;
  logic [LVL_W-1:0] lvl_pop;
  logic [LVL_W-1:0] push_sh;

  assign head = acc[ACC_W-1 -: 16];

  // Pop first, then place an incoming word right below the remaining bits.
  always_comb begin
    acc_pop  = acc << pop_n;
    lvl_pop  = level - LVL_W'(pop_n);
    word_ext = {{(ACC_W - WORD_W){1'b0}}, word};
    push_sh  = LVL_ROOM - lvl_pop;
  end

  // Accumulator and level registers; flush wins over any push.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc   <= '0;
      level <= '0;
    end else if (flush) begin
      acc   <= '0;
      level <= '0;
    end else if (push) begin
      acc   <= acc_pop | (word_ext << push_sh);
      level <= lvl_pop + LVL_WORD;
    end else begin
      acc   <= acc_pop;
      level <= lvl_pop;
    end
  end

endmodule

// File: rtl/cel_pack_row_decoder.sv
// Decodes one row of packed CEL source data into a one-pixel-per-cycle stream.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for start
// ST_HDR    | waiting for 16 bits, decode row offset
// ST_PKT    | waiting for 8 bits, decode packet type/count
// ST_LIT    | emitting literal pixels straight from the accumulator
// ST_TRN    | emitting transparent pixels, no bits consumed
// ST_REP_LD | loading the single repeat value
// ST_REP    | emitting the repeat value
// ST_DRAIN  | dropping words until the row's word count is reached
module cel_pack_row_decoder
  import cel_pack_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int ACC_W  = 64,
  parameter int CNT_W  = 6
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [2:0]        bpp,
  input  logic              start,
  input  logic [WORD_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic [15:0]       pix_data,
  output logic              pix_transp,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              row_done,
  output logic [9:0]        row_words,
  output logic              busy,
  output logic              err
);

  localparam int LVL_W = $clog2(ACC_W + 1);
  localparam logic [LVL_W-1:0] LVL_8    = LVL_W'(8);
  localparam logic [LVL_W-1:0] LVL_16   = LVL_W'(16);
  localparam logic [LVL_W-1:0] LVL_ROOM = LVL_W'(ACC_W - WORD_W);
  localparam logic [CNT_W:0]   REM_ONE  = (CNT_W + 1)'(1);

  state_t             state;
  logic [2:0]         bpp_q;
  logic [10:0]        words_taken;
  logic [10:0]        row_limit;
  logic [10:0]        limit;
  logic               hdr_done;
  logic [CNT_W:0]     remaining;
  logic [15:0]        rep_val;

  logic [15:0]        head;
  logic [LVL_W-1:0]   level;
  logic [4:0]         nbits;
  logic [LVL_W-1:0]   need;
  logic [4:0]         pop_n;
  logic               flush;
  logic               accept;
  logic               fire;
  logic               starved;
  logic               wide;
  logic [15:0]        lit_pix;

  cel_bit_accum #(
    .WORD_W(WORD_W),
    .ACC_W (ACC_W),
    .LVL_W (LVL_W)
  ) u_accum (
    .clock  (clock),
    .reset_n(reset_n),
    .flush  (flush),
    .push   (accept),
    .word   (din),
    .pop_n  (pop_n),
    .head   (head),
    .level  (level)
  );

  assign row_words = row_limit[9:0];

  // Handshake and pixel outputs, all decoded from registered state.
  always_comb begin
    nbits      = bpp_bits(bpp_q);
    need       = LVL_W'(nbits);
    wide       = (bpp_q == BPP_8) || (bpp_q == BPP_16);
    limit      = hdr_done ? row_limit : 11'd2;
    starved    = words_taken >= limit;
    busy       = state != ST_IDLE;
    din_ready  = busy && (level <= LVL_ROOM) && !starved;
    accept     = din_valid && din_ready;
    lit_pix    = head >> (5'd16 - nbits);
    pix_valid  = ((state == ST_LIT) && (level >= need)) ||
                 (state == ST_TRN) || (state == ST_REP);
    pix_transp = state == ST_TRN;
    pix_data   = (state == ST_LIT) ? lit_pix :
                 (state == ST_REP) ? rep_val : 16'd0;
    fire       = pix_valid && pix_ready;
  end

  // Bits to consume and when to discard the accumulator.
  always_comb begin
    pop_n = 5'd0;
    flush = (state == ST_DRAIN) || ((state == ST_IDLE) && start);
    case (state)
      ST_HDR:    if (level >= LVL_16) pop_n = wide ? 5'd16 : 5'd8;
      ST_PKT:    if (level >= LVL_8) pop_n = 5'd8;
      ST_LIT:    if (fire) pop_n = nbits;
      ST_REP_LD: if (level >= need) pop_n = nbits;
      default:   pop_n = 5'd0;
    endcase
  end

  // Row sequencing FSM with registered status outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      bpp_q       <= '0;
      words_taken <= '0;
      row_limit   <= '0;
      hdr_done    <= 1'b0;
      remaining   <= '0;
      rep_val     <= '0;
      err         <= 1'b0;
      row_done    <= 1'b0;
    end else begin
      row_done <= 1'b0;
      if (accept) words_taken <= words_taken + 11'd1;
      case (state)
        ST_IDLE: begin
          if (start) begin
            bpp_q       <= bpp;
            words_taken <= '0;
            err         <= 1'b0;
            hdr_done    <= 1'b0;
            state       <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (level >= LVL_16) begin
            hdr_done <= 1'b1;
            if (wide) row_limit <= {1'b0, head[9:0]} + 11'd2;
            else      row_limit <= {3'b000, head[15:8]} + 11'd2;
            if (nbits == 5'd0) begin
              err   <= 1'b1;
              state <= ST_DRAIN;
            end else begin
              state <= ST_PKT;
            end
          end
        end
        ST_PKT: begin
          if (level >= LVL_8) begin
            remaining <= {1'b0, head[13 -: CNT_W]} + REM_ONE;
            case (head[15:14])
              PACK_LITERAL: state <= ST_LIT;
              PACK_TRANSP:  state <= ST_TRN;
              PACK_REPEAT:  state <= ST_REP_LD;
              default:      state <= ST_DRAIN;
            endcase
          end else if (starved) begin
            state <= ST_DRAIN;
          end
        end
        ST_LIT: begin
          if (fire) begin
            remaining <= remaining - REM_ONE;
            if (remaining == REM_ONE) state <= ST_PKT;
          end else if ((level < need) && starved) begin
            err   <= 1'b1;
            state <= ST_DRAIN;
          end
        end
        ST_TRN, ST_REP: begin
          if (fire) begin
            remaining <= remaining - REM_ONE;
            if (remaining == REM_ONE) state <= ST_PKT;
          end
        end
        ST_REP_LD: begin
          if (level >= need) begin
            rep_val <= lit_pix;
            state   <= ST_REP;
          end else if (starved) begin
            err   <= 1'b1;
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (words_taken >= row_limit) begin
            row_done <= 1'b1;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cel_pack_row_decoder.sv
// Bench for the packed CEL row decoder: rows are built as bit strings, a
// bit-pointer reference model derives the expected pixels, row size and error.
module tb_cel_pack_row_decoder;

  logic        clock;
  logic        reset_n;
  logic [2:0]  bpp;
  logic        start;
  logic [31:0] din;
  logic        din_valid;
  logic        din_ready;
  logic [15:0] pix_data;
  logic        pix_transp;
  logic        pix_valid;
  logic        pix_ready;
  logic        row_done;
  logic [9:0]  row_words;
  logic        busy;
  logic        err;

  cel_pack_row_decoder dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .bpp       (bpp),
    .start     (start),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .pix_data  (pix_data),
    .pix_transp(pix_transp),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .row_done  (row_done),
    .row_words (row_words),
    .busy      (busy),
    .err       (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [31:0] outs;
  assign outs = {din_ready, pix_valid, pix_transp, pix_data, row_done, row_words, busy, err};

  int          checks = 0;
  int          errors = 0;
  logic [31:0] words [0:255];
  logic [16:0] exp_pix [$];
  int          exp_rw;
  logic        exp_err;
  bit          q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int nbits_of(input int code);
    case (code)
      1: return 1;
      2: return 2;
      3: return 4;
      4: return 6;
      5: return 8;
      6: return 16;
      default: return 0;
    endcase
  endfunction

  function automatic int rd(input int p, input int n);
    int v = 0;
    for (int i = 0; i < n; i++) v = (v << 1) | int'(words[(p + i) / 32][31 - ((p + i) % 32)]);
    return v;
  endfunction

  task automatic put(input int v, input int n);
    for (int i = n - 1; i >= 0; i--) q.push_back(v[i]);
  endtask

  task automatic pack();
    for (int w = 0; w < 256; w++) words[w] = $urandom;
    for (int p = 0; p < q.size(); p++) words[p / 32][31 - (p % 32)] = q[p];
    q.delete();
  endtask

  // Walks the row with a bit pointer limited to the row's own word count.
  task automatic model(input int code);
    int n, pos, avail, off, typ, cnt, v;
    exp_pix.delete();
    exp_err = 1'b0;
    n = nbits_of(code);
    if (code == 5 || code == 6) begin off = rd(6, 10); pos = 16; end
    else begin off = rd(0, 8); pos = 8; end
    exp_rw = off + 2;
    avail  = exp_rw * 32;
    if (n == 0) begin exp_err = 1'b1; return; end
    while (1) begin
      if (pos + 8 > avail) return;
      typ = rd(pos, 2);
      cnt = rd(pos + 2, 6);
      pos += 8;
      if (typ == 0) return;
      if (typ == 1) begin
        for (int i = 0; i <= cnt; i++) begin
          if (pos + n > avail) begin exp_err = 1'b1; return; end
          exp_pix.push_back({1'b0, 16'(rd(pos, n))});
          pos += n;
        end
      end else if (typ == 2) begin
        for (int i = 0; i <= cnt; i++) exp_pix.push_back(17'h10000);
      end else begin
        if (pos + n > avail) begin exp_err = 1'b1; return; end
        v = rd(pos, n);
        pos += n;
        for (int i = 0; i <= cnt; i++) exp_pix.push_back({1'b0, 16'(v)});
      end
    end
  endtask

  task automatic build_random(input int code);
    int n, hb, need, rw, h;
    n = nbits_of(code);
    for (int k = $urandom_range(1, 5); k > 0; k--) begin
      int typ, cnt;
      typ = $urandom_range(1, 3);
      cnt = $urandom_range(0, 15);
      put(typ, 2);
      put(cnt, 6);
      if (typ == 1) for (int i = 0; i <= cnt; i++) put($urandom, n);
      if (typ == 3) put($urandom, n);
    end
    if ($urandom_range(0, 1) == 1) put(0, 8);
    hb   = (code == 5 || code == 6) ? 16 : 8;
    need = (hb + q.size() + 31) / 32;
    if (need < 2) need = 2;
    rw = ($urandom_range(0, 3) == 0) ? $urandom_range(2, need) : need;
    h  = (hb == 16) ? (($urandom_range(0, 63) << 10) | (rw - 2)) : (rw - 2);
    for (int i = 0; i < hb; i++) q.push_front(h[i]);
    pack();
  endtask

  task automatic run_row(input int code, input bit stall);
    int   idx = 0;
    bit   done = 0;
    bit   seen_pix = 0;
    int   stall_left = 0;
    bit   pend = 0;
    logic [17:0] snap = '0;
    @(negedge clock);
    bpp = 3'(code); start = 1'b1; din_valid = 1'b0; pix_ready = 1'b0;
    @(negedge clock);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("din_ready_after_start", din_ready, 1);
    chk("err_cleared", err, 0);
    for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
      if (pend) chk("pix_hold", {pix_valid, pix_transp, pix_data}, snap);
      if (row_done) begin
        done = 1;
      end else begin
        din       = words[idx];
        din_valid = ($urandom_range(0, 3) != 0);
        pix_ready = ($urandom_range(0, 3) != 0);
        start     = ($urandom_range(0, 15) == 0);
        if (stall_left > 0) begin
          pix_ready = 1'b0;
          din_valid = 1'b1;
          stall_left--;
          if (stall_left == 0) begin
            chk("din_ready_full", din_ready, 0);
            chk("pix_valid_stall", pix_valid, 1);
          end
        end
        if (pix_valid && pix_ready) begin
          if (exp_pix.size() == 0) chk("extra_pixel", {pix_transp, pix_data}, 17'h1ffff);
          else chk("pixel", {pix_transp, pix_data}, exp_pix.pop_front());
          if (stall && !seen_pix) stall_left = 5;
          seen_pix = 1;
        end
        if (din_valid && din_ready) idx++;
        pend = pix_valid && !pix_ready;
        snap = {pix_valid, pix_transp, pix_data};
        @(negedge clock);
      end
    end
    start = 1'b0; din_valid = 1'b0; pix_ready = 1'b0;
    chk("row_done_seen", done, 1);
    chk("row_words", row_words, exp_rw);
    chk("words_taken", idx, exp_rw);
    chk("err", err, exp_err);
    chk("pixels_left", exp_pix.size(), 0);
    chk("busy_idle", busy, 0);
    @(negedge clock);
    chk("row_done_pulse", row_done, 0);
  endtask

  initial begin
    int idx;
    reset_n = 1'b0; start = 1'b0; din_valid = 1'b0; pix_ready = 1'b0; bpp = '0; din = '0;
    #12;
    chk("reset_outputs", outs, 0);
    @(negedge clock);
    reset_n = 1'b1;

    // 8bpp literal run, EOL, drain to 4 words
    put(16'h0002, 16); put(8'h45, 8);
    for (int i = 1; i <= 6; i++) put(i * 8'h11, 8);
    put(0, 8); pack(); model(5); run_row(5, 0);

    // 6bpp literal of 16 pixels straddling word boundaries
    put(8'h02, 8); put(8'h4F, 8);
    for (int i = 0; i < 16; i++) put(i * 4 + 3, 6);
    put(0, 8); pack(); model(4); run_row(4, 0);

    // 4bpp transparent run then repeat of 0xA
    put(8'h00, 8); put(8'h83, 8); put(8'hC2, 8); put(4'hA, 4); put(0, 8);
    pack(); model(3); run_row(3, 0);

    // 8bpp literal stalled downstream, then words run out mid-packet
    put(16'h0006, 16); put(8'h7F, 8);
    for (int i = 0; i < 40; i++) put(i + 1, 8);
    pack(); model(5); run_row(5, 1);

    // unsupported bpp codes drain the row and flag err
    put(8'h03, 8); pack(); model(7); run_row(7, 0);
    put(8'h00, 8); pack(); model(0); run_row(0, 0);

    for (int r = 0; r < 30; r++) begin
      int code;
      code = $urandom_range(1, 6);
      build_random(code);
      model(code);
      run_row(code, 0);
    end

    // asynchronous reset in the middle of a row
    put(16'h0002, 16); put(8'h45, 8);
    for (int i = 1; i <= 6; i++) put(i * 8'h11, 8);
    pack();
    @(negedge clock);
    bpp = 3'd5; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      din = words[idx]; din_valid = 1'b1; pix_ready = 1'b0;
      if (din_ready) idx++;
      @(negedge clock);
    end
    chk("busy_before_reset", busy, 1);
    #2 reset_n = 1'b0;
    #1 chk("reset_async", outs, 0);
    @(negedge clock);
    reset_n = 1'b1; din_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      chk("no_row_done_after_reset", {row_done, busy}, 0);
    end

    build_random(3); model(3); run_row(3, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
